alu_ctrl_pipe: RTL and testbench

//  Registered, handshaked successor of the single-cycle ALU control decoder for the pipelined CPU.

---
 rtl/alu_ctrl_pkg.sv | 36 +++
 rtl/alu_ctrl_pipe_if.sv | 34 +++
 rtl/alu_ctrl_dec.sv | 60 ++++++
 rtl/alu_ctrl_pipe.sv | 157 +++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the pipelined ALU control block: ALUOp/funct codes, ALUCtrl codes,
// result-mux selects and the MDU sequencing state type.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_R     = 3'b010;
  localparam logic [2:0] OP_BNE   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_ORI   = 3'b101;
  localparam logic [2:0] OP_SLTIU = 3'b110;
  localparam logic [2:0] OP_LUI   = 3'b111;

  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] FUR_ALU = 2'b00;
  localparam logic [1:0] FUR_SHF = 2'b01;
  localparam logic [1:0] FUR_LUI = 2'b10;
  localparam logic [1:0] FUR_MDU = 2'b11;

  typedef enum logic {ST_IDLE, ST_MDU_WAIT} state_t;

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// ID-side request and EX-side control-word bundle of the pipelined ALU control block.
interface alu_ctrl_pipe_if #(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
);
  logic               valid_i;
  logic               ready_o;
  logic [FUNCT_W-1:0] funct_i;
  logic [ALUOP_W-1:0] ALUOp_i;
  logic               stall_i;
  logic               flush_i;
  logic               mdu_done_i;
  logic               valid_o;
  logic [CTRL_W-1:0]  ALUCtrl_o;
  logic [1:0]         fur_slt_o;
  logic               sra_scr_o;
  logic               be_o;
  logic               illegal_o;
  logic               mdu_start_o;
  logic               mdu_tmo_o;

  modport master (
    output valid_i, funct_i, ALUOp_i, stall_i, flush_i, mdu_done_i,
    input  ready_o, valid_o, ALUCtrl_o, fur_slt_o, sra_scr_o, be_o, illegal_o,
           mdu_start_o, mdu_tmo_o
  );

  modport slave (
    input  valid_i, funct_i, ALUOp_i, stall_i, flush_i, mdu_done_i,
    output ready_o, valid_o, ALUCtrl_o, fur_slt_o, sra_scr_o, be_o, illegal_o,
           mdu_start_o, mdu_tmo_o
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Pure combinational ALUOp/funct decode table. mult is an MDU op only when ALU_CTRL_MDU_EN
// is defined; otherwise it falls through as illegal.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
) (
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic [1:0]         fur_slt_o,
  output logic               sra_scr_o,
  output logic               be_o,
  output logic               illegal_o,
  output logic               is_mdu_o
);
  logic [3:0] code;

  always_comb begin
    code      = ALU_ADD;
    fur_slt_o = FUR_ALU;
    sra_scr_o = 1'b0;
    be_o      = 1'b0;
    illegal_o = 1'b0;
    is_mdu_o  = 1'b0;
    case (ALUOp_i)
      ALUOP_W'(OP_BEQ):   code = ALU_SUB;
      ALUOP_W'(OP_BNE):   begin code = ALU_SUB; be_o = 1'b1; end
      ALUOP_W'(OP_ADDI):  code = ALU_ADD;
      ALUOP_W'(OP_ORI):   code = ALU_OR;
      ALUOP_W'(OP_SLTIU): code = ALU_SLTU;
      ALUOP_W'(OP_LUI):   begin code = ALU_AND; fur_slt_o = FUR_LUI; end
      ALUOP_W'(OP_R): begin
        case (funct_i)
          FUNCT_W'(F_ADDU): code = ALU_ADD;
          FUNCT_W'(F_SUBU): code = ALU_SUB;
          FUNCT_W'(F_AND):  code = ALU_AND;
          FUNCT_W'(F_OR):   code = ALU_OR;
          FUNCT_W'(F_SLT):  code = ALU_SLT;
          FUNCT_W'(F_SRA):  begin code = ALU_AND; fur_slt_o = FUR_SHF; end
          FUNCT_W'(F_SRAV): begin code = ALU_AND; fur_slt_o = FUR_SHF; sra_scr_o = 1'b1; end
          FUNCT_W'(F_MULT): begin
`ifdef ALU_CTRL_MDU_EN
            is_mdu_o  = 1'b1;
`else
            illegal_o = 1'b1;
`endif
          end
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign ctrl_o = CTRL_W'(code);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU control stage with stall hold, flush and (with ALU_CTRL_MDU_EN
// defined) a start/done MDU sequencer guarded by a saturating timeout counter.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4,
  parameter int MDU_TMO = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_ctrl_pipe_if.slave bus
);
  logic [CTRL_W-1:0] dec_ctrl, ctrl_p1, ctrl_d;
  logic [1:0]        dec_sel, sel_p1, sel_d;
  logic              dec_scr, dec_be, dec_ill, dec_is_mdu;
  logic              scr_p1, scr_d, be_p1, be_d, ill_p1, ill_d;
  logic              vld_p1, vld_d, start_p1, start_d, tmo_q, tmo_d;
  logic              live_q, idle, accept, hold;

  alu_ctrl_dec #(.FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W), .CTRL_W(CTRL_W)) u_dec (
    .ALUOp_i   (bus.ALUOp_i),
    .funct_i   (bus.funct_i),
    .ctrl_o    (dec_ctrl),
    .fur_slt_o (dec_sel),
    .sra_scr_o (dec_scr),
    .be_o      (dec_be),
    .illegal_o (dec_ill),
    .is_mdu_o  (dec_is_mdu)
  );

`ifdef ALU_CTRL_MDU_EN
  localparam int CNT_W = $clog2(MDU_TMO);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign idle = (state_q == ST_IDLE);
`else
  logic unused_cfg;
  assign unused_cfg = bus.mdu_done_i ^ dec_is_mdu ^ (MDU_TMO < 2);
  assign idle       = 1'b1;
`endif

  // live_q keeps ready_o low through reset and for the first cycle after release
  assign bus.ready_o = live_q & idle & ~(vld_p1 & bus.stall_i);
  assign accept      = bus.valid_i & bus.ready_o;
  assign hold        = vld_p1 & bus.stall_i & ~bus.flush_i;

  always_comb begin
    vld_d   = vld_p1;
    ctrl_d  = ctrl_p1;
    sel_d   = sel_p1;
    scr_d   = scr_p1;
    be_d    = be_p1;
    ill_d   = ill_p1;
    start_d = 1'b0;
    tmo_d   = tmo_q;
`ifdef ALU_CTRL_MDU_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
`endif
    if (!hold) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
      sel_d  = FUR_ALU;
      scr_d  = 1'b0;
      be_d   = 1'b0;
      ill_d  = 1'b0;
    end
    if (!hold && !bus.flush_i) begin
`ifdef ALU_CTRL_MDU_EN
      if (state_q == ST_MDU_WAIT) begin
        if (bus.mdu_done_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          vld_d   = 1'b1;
          sel_d   = FUR_MDU;
          ctrl_d  = CTRL_W'(ALU_AND);
        end else if (cnt_q == CNT_W'(MDU_TMO - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          vld_d   = 1'b1;
          ill_d   = 1'b1;
          ctrl_d  = CTRL_W'(ALU_ADD);
          tmo_d   = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end else if (accept && dec_is_mdu) begin
        state_d = ST_MDU_WAIT;
        cnt_d   = '0;
        start_d = 1'b1;
      end else
`endif
      if (accept) begin
        vld_d  = 1'b1;
        ctrl_d = dec_ctrl;
        sel_d  = dec_sel;
        scr_d  = dec_scr;
        be_d   = dec_be;
        ill_d  = dec_ill;
      end
    end
  end

  // ---- p1: EX-stage control word register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q   <= 1'b0;
      vld_p1   <= 1'b0;
      ctrl_p1  <= '0;
      sel_p1   <= '0;
      scr_p1   <= 1'b0;
      be_p1    <= 1'b0;
      ill_p1   <= 1'b0;
      start_p1 <= 1'b0;
      tmo_q    <= 1'b0;
`ifdef ALU_CTRL_MDU_EN
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
`endif
    end else begin
      live_q   <= 1'b1;
      vld_p1   <= vld_d;
      ctrl_p1  <= ctrl_d;
      sel_p1   <= sel_d;
      scr_p1   <= scr_d;
      be_p1    <= be_d;
      ill_p1   <= ill_d;
      start_p1 <= start_d;
      tmo_q    <= tmo_d;
`ifdef ALU_CTRL_MDU_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.valid_o     = vld_p1;
  assign bus.ALUCtrl_o   = ctrl_p1;
  assign bus.fur_slt_o   = sel_p1;
  assign bus.sra_scr_o   = scr_p1;
  assign bus.be_o        = be_p1;
  assign bus.illegal_o   = ill_p1;
  assign bus.mdu_start_o = start_p1;
  assign bus.mdu_tmo_o   = tmo_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench for alu_ctrl_pipe: directed handshake/MDU scenarios plus randomized decode
// traffic checked against a mnemonic-level reference table. Honours ALU_CTRL_MDU_EN.
module tb_alu_ctrl_pipe;
  typedef struct packed {
    logic [3:0] ctrl;
    logic [1:0] sel;
    logic       scr;
    logic       be;
    logic       ill;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_pipe_if #(.FUNCT_W(6), .ALUOP_W(3), .CTRL_W(4)) bus();

  alu_ctrl_pipe #(.FUNCT_W(6), .ALUOP_W(3), .CTRL_W(4), .MDU_TMO(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  word_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic word_t mk(input int ctrl, input int sel, input bit scr, input bit be);
    word_t w;
    w.ctrl = 4'(ctrl); w.sel = 2'(sel); w.scr = scr; w.be = be; w.ill = 1'b0;
    return w;
  endfunction

  // Reference: instruction mnemonic -> EX control word; anything unlisted is illegal.
  function automatic word_t ref_word(input int op, input int fn);
    word_t w;
    w = mk(2, 0, 0, 0);
    w.ill = 1'b1;
    case (op)
      1: w = mk(6, 0, 0, 0);   // beq
      3: w = mk(6, 0, 0, 1);   // bne
      4: w = mk(2, 0, 0, 0);   // addi
      5: w = mk(1, 0, 0, 0);   // ori
      6: w = mk(15, 0, 0, 0);  // sltiu
      7: w = mk(0, 2, 0, 0);   // lui
      2: case (fn)
           'h21: w = mk(2, 0, 0, 0);  // addu
           'h23: w = mk(6, 0, 0, 0);  // subu
           'h24: w = mk(0, 0, 0, 0);  // and
           'h25: w = mk(1, 0, 0, 0);  // or
           'h2a: w = mk(7, 0, 0, 0);  // slt
           'h03: w = mk(0, 1, 0, 0);  // sra
           'h07: w = mk(0, 1, 1, 0);  // srav
           default: ;
         endcase
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: every presented word must match the oldest expected one; it leaves on transfer or flush.
  always @(negedge clk) begin
    word_t got;
    if (bus.valid_o === 1'b1) begin
      got = {bus.ALUCtrl_o, bus.fur_slt_o, bus.sra_scr_o, bus.be_o, bus.illegal_o};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid got_word=%0h exp=none t=%0t", got, $time);
      end else begin
        chk("word", 32'(got), 32'(exp_q[0]));
        if (!bus.stall_i || bus.flush_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Presents an op until accepted; returns one cycle after the accepting edge.
  task automatic issue(input int op, input int fn, input bit push);
    int n;
    n = 0;
    bus.valid_i = 1'b1; bus.ALUOp_i = 3'(op); bus.funct_i = 6'(fn);
    @(negedge clk);
    while (bus.ready_o !== 1'b1 && n < 40) begin
      next_cycle(); @(negedge clk); n++;
    end
    if (n >= 40) begin
      checks++; failures++;
      $display("FAIL issue_timeout got=ready_low exp=accept t=%0t", $time);
    end
    if (push) exp_q.push_back(ref_word(op, fn));
    next_cycle();
    bus.valid_i = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit shown, acc, v, st, fl;
    int op, fn;
    int fl_list[7];
    fl_list = '{'h21, 'h23, 'h24, 'h25, 'h2a, 'h03, 'h07};
    bus.valid_i = 0; bus.ALUOp_i = 0; bus.funct_i = 0;
    bus.stall_i = 0; bus.flush_i = 0; bus.mdu_done_i = 0;

    // reset and release
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_ready", bus.ready_o, 0);
    chk("rst_word", {bus.ALUCtrl_o, bus.fur_slt_o, bus.sra_scr_o, bus.be_o, bus.illegal_o}, 0);
    chk("rst_start", bus.mdu_start_o, 0);
    chk("rst_tmo", bus.mdu_tmo_o, 0);
    next_cycle();
    @(negedge clk);
    chk("rst_ready_after", bus.ready_o, 1);
    next_cycle();

    // subu, one-cycle latency then drop
    issue(2, 'h23, 1);
    @(negedge clk);
    chk("subu_valid", bus.valid_o, 1);
    next_cycle();
    @(negedge clk);
    chk("subu_drop", bus.valid_o, 0);
    next_cycle();

    // beq held under a 3-cycle stall
    issue(1, 0, 1);
    bus.stall_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("beq_hold_valid", bus.valid_o, 1);
      chk("beq_hold_ready", bus.ready_o, 0);
      next_cycle();
    end
    bus.stall_i = 1'b0;
    @(negedge clk);
    chk("beq_release_valid", bus.valid_o, 1);
    next_cycle();
    @(negedge clk);
    chk("beq_drop", bus.valid_o, 0);
    next_cycle();

    // randomized decode traffic with random stall/flush
    shown = 1'b0;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 7);
      fn = ($urandom_range(0, 1) == 0) ? fl_list[$urandom_range(0, 6)] : int'($urandom_range(0, 63));
      if (fn == 'h18) fn = 'h3f;
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 19) == 0);
      bus.valid_i = v; bus.ALUOp_i = 3'(op); bus.funct_i = 6'(fn);
      bus.stall_i = st; bus.flush_i = fl;
      @(negedge clk);
      chk("rnd_ready", bus.ready_o, !(shown && st));
      acc = v && !(shown && st) && !fl;
      if (acc) exp_q.push_back(ref_word(op, fn));
      shown = acc || (shown && st && !fl);
      next_cycle();
    end
    bus.valid_i = 0; bus.stall_i = 0; bus.flush_i = 0;
    repeat (2) begin @(negedge clk); next_cycle(); end
    chk("rnd_drained", exp_q.size(), 0);

    // flush kills a word held under stall
    issue(2, 'h21, 1);
    bus.stall_i = 1'b1;
    @(negedge clk);
    next_cycle();
    bus.flush_i = 1'b1;
    @(negedge clk);
    next_cycle();
    bus.flush_i = 1'b0; bus.stall_i = 1'b0;
    @(negedge clk);
    chk("flush_held_valid", bus.valid_o, 0);
    next_cycle();

`ifdef ALU_CTRL_MDU_EN
    // mult completed by done in the 5th wait cycle
    issue(2, 'h18, 0);
    for (int w = 1; w <= 5; w++) begin
      bus.mdu_done_i = (w == 5);
      @(negedge clk);
      chk("mult_wait_ready", bus.ready_o, 0);
      chk("mult_wait_valid", bus.valid_o, 0);
      chk("mult_start", bus.mdu_start_o, (w == 1));
      if (w == 5) exp_q.push_back(mk(0, 3, 0, 0));
      next_cycle();
    end
    bus.mdu_done_i = 1'b0;
    @(negedge clk);
    chk("mult_result_valid", bus.valid_o, 1);
    chk("mult_tmo_clear", bus.mdu_tmo_o, 0);
    next_cycle();

    // done while idle is ignored
    bus.mdu_done_i = 1'b1;
    @(negedge clk);
    next_cycle();
    bus.mdu_done_i = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", bus.valid_o, 0);
    next_cycle();

    // mult without done times out after MDU_TMO=8 cycles
    issue(2, 'h18, 0);
    for (int w = 1; w <= 8; w++) begin
      @(negedge clk);
      chk("tmo_wait_ready", bus.ready_o, 0);
      chk("tmo_wait_valid", bus.valid_o, 0);
      chk("tmo_wait_flag", bus.mdu_tmo_o, 0);
      if (w == 8) begin
        exp_q.push_back(mk(2, 0, 0, 0));
        exp_q[$].ill = 1'b1;
      end
      next_cycle();
    end
    @(negedge clk);
    chk("tmo_flag", bus.mdu_tmo_o, 1);
    chk("tmo_valid", bus.valid_o, 1);
    chk("tmo_illegal", bus.illegal_o, 1);
    chk("tmo_ready", bus.ready_o, 1);
    next_cycle();
    @(negedge clk);
    chk("tmo_sticky", bus.mdu_tmo_o, 1);
    next_cycle();

    // flush beats a same-cycle done in MDU_WAIT
    issue(2, 'h18, 0);
    @(negedge clk);
    next_cycle();
    bus.flush_i = 1'b1; bus.mdu_done_i = 1'b1;
    @(negedge clk);
    next_cycle();
    bus.flush_i = 1'b0; bus.mdu_done_i = 1'b0;
    @(negedge clk);
    chk("flush_mdu_valid", bus.valid_o, 0);
    chk("flush_mdu_ready", bus.ready_o, 1);
    next_cycle();

    // reset mid-wait returns idle and clears the sticky timeout
    issue(2, 'h18, 0);
    @(negedge clk);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mdu_tmo", bus.mdu_tmo_o, 0);
    chk("rst_mdu_valid", bus.valid_o, 0);
    chk("rst_mdu_start", bus.mdu_start_o, 0);
    next_cycle();
    @(negedge clk);
    chk("rst_mdu_ready", bus.ready_o, 1);
    next_cycle();
`else
    // without the MDU, mult is an ordinary illegal op
    issue(2, 'h18, 1);
    @(negedge clk);
    chk("mult_illegal", bus.illegal_o, 1);
    chk("mult_no_start", bus.mdu_start_o, 0);
    chk("mult_ready", bus.ready_o, 1);
    next_cycle();
    bus.mdu_done_i = 1'b1;
    @(negedge clk);
    chk("no_mdu_tmo", bus.mdu_tmo_o, 0);
    next_cycle();
    bus.mdu_done_i = 1'b0;
    @(negedge clk);
    chk("no_mdu_done_ignored", bus.valid_o, 0);
    next_cycle();
`endif

    // undefined funct under R-type
    issue(2, 'h3f, 1);
    @(negedge clk);
    chk("undef_illegal", bus.illegal_o, 1);
    chk("undef_valid", bus.valid_o, 1);
    next_cycle();
    repeat (3) begin @(negedge clk); next_cycle(); end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
